// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Start, parity and stop bits surrounding the data bits of one frame.
    localparam int unsigned FRAME_OVERHEAD = 3;

    function automatic int unsigned frame_bits(input int unsigned n);
        return n + FRAME_OVERHEAD;
    endfunction

    // Parity bit the transmitter attaches to a data word (zero-extension is harmless).
    function automatic logic parity_of(input logic [63:0] data, input logic odd);
        return odd ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO buffering received words; head holds the last
// popped word while empty.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [PW:0]      count_q;
    logic [WIDTH-1:0] hold_q;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = empty_o ? hold_q : mem_q[rptr_q];

    // Storage write; contents need no reset since the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Pointer and occupancy tracking; the popped word is retained for the empty head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop_i) begin
                rptr_q <= rptr_q + PW'(1);
                hold_q <= mem_q[rptr_q];
            end
            count_q <= count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: samples start / N data (MSB first) / parity / stop,
// flags bad frames and queues good words for a valid/ready consumer.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         parity_err,
    output logic         frame_err,
    output logic         overflow
);

    localparam int unsigned FRAME_BITS = frame_bits(N);
    localparam int unsigned SAMPLE_OFS = (BIT_CYCLES - 1) / 2;
    localparam int unsigned CW         = $clog2(BIT_CYCLES) + 1;
    localparam int unsigned BW         = $clog2(FRAME_BITS);

    rx_state_t      state_q;
    logic [CW-1:0]  cnt_q;
    logic [BW-1:0]  bitcnt_q;
    logic [N-1:0]   shreg_q;
    logic           par_q;
    logic           armed_q;
    logic           perr_q;
    logic           ferr_q;
    logic           ovf_q;

    logic           at_sample;
    logic           stop_eval;
    logic           par_ok;
    logic           pop;
    logic           push;
    logic           fifo_full;
    logic           fifo_empty;

    // Sample-point detection and stop-bit verdict for the current cycle.
    always_comb begin
        at_sample = (state_q == START) ? (cnt_q == CW'(SAMPLE_OFS))
                                       : (cnt_q == CW'(BIT_CYCLES));
        stop_eval = (state_q == STOP) && at_sample;
        par_ok    = (par_q == parity_of(64'(shreg_q), PARITY_ODD != 0));
        pop       = out_valid && out_ready;
        push      = stop_eval && rx && par_ok && (!fifo_full || pop);
    end

    // Frame FSM; cnt_q counts cycles since the previous sample (or start detect).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            armed_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovf_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (rx) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        // Zero offset means the detect cycle is itself the start sample.
                        cnt_q    <= CW'(1);
                        bitcnt_q <= '0;
                        state_q  <= (SAMPLE_OFS == 0) ? DATA : START;
                    end
                end
                START: begin
                    if (at_sample) begin
                        cnt_q   <= rx ? '0 : CW'(1);
                        state_q <= rx ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (at_sample) begin
                        cnt_q   <= CW'(1);
                        shreg_q <= {shreg_q[N-2:0], rx};
                        if (bitcnt_q == BW'(N - 1)) begin
                            bitcnt_q <= '0;
                            state_q  <= PARITY;
                        end else begin
                            bitcnt_q <= bitcnt_q + BW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                PARITY: begin
                    if (at_sample) begin
                        cnt_q   <= CW'(1);
                        par_q   <= rx;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (at_sample) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (!rx) begin
                            ferr_q  <= 1'b1;
                            armed_q <= 1'b0;
                        end else if (!par_ok) begin
                            perr_q <= 1'b1;
                        end else if (fifo_full && !pop) begin
                            ovf_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;
    assign out_valid  = !fifo_empty;

    uart_rx_fifo #(
        .WIDTH(N),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .data_i (shreg_q),
        .pop_i  (pop),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .head_o (out_data)
    );

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Serial-to-parallel receive stage that consumes the line produced by the team's UART transmitter and delivers checked bytes to the core. The frame format is start bit (0), N data bits MSB first, one parity bit, then stop bit (1). The block samples the line at a configurable bit period, checks parity and the stop bit, and buffers good words in a small FIFO. Downstream logic reads that FIFO through a valid/ready interface.

Parameters:
N, 8, data bits per frame
BIT_CYCLES, 1, clocks per bit (>=1); sample point is offset (BIT_CYCLES-1)/2 into each bit
PARITY_ODD, 0, 0: expected parity bit = ^data; 1: expected parity bit = ~^data
FIFO_DEPTH, 4, good-word buffer depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rx  in  1  serial line, idle high
out_data  out  N  FIFO head word (show-ahead)
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data when out_valid & out_ready
parity_err  out  1  one-cycle pulse: received parity mismatch, frame dropped
frame_err  out  1  one-cycle pulse: stop bit sampled 0, frame dropped
overflow  out  1  one-cycle pulse: good frame dropped because FIFO full

Behaviour:
- Reset (sync, active-high): state IDLE, FIFO empty, out_valid=0, out_data=0, all error pulses 0, bit/cycle counters 0, armed=0. Reset mid-frame discards the partial frame with no flags.
- armed: set when rx==1 is sampled in IDLE; cleared after reset and after frame_err. A start is recognised only when armed=1. This rejects line-low after reset and break conditions.
- Timing reference: rx==0 seen in IDLE with armed=1 at cycle t. Bit k (k=0 start, 1..N data, N+1 parity, N+2 stop) is sampled at t + k*BIT_CYCLES + (BIT_CYCLES-1)/2.
- States and transitions:
  - IDLE -> START on armed & rx==0.
  - START: at its sample point, rx==1 is a false start -> IDLE, no flags; rx==0 -> DATA. With BIT_CYCLES=1 the start is confirmed in the detect cycle.
  - DATA: shift in N samples MSB first, shreg <= {shreg[N-2:0], rx}, then -> PARITY.
  - PARITY: capture the parity sample, then -> STOP.
  - STOP: on the stop sample, evaluate the frame and go to IDLE.
- Stop-sample evaluation, in priority order:
  - stop==0: frame_err=1, armed=0.
  - else parity mismatch: parity_err=1.
  - else FIFO full and no pop this cycle: overflow=1.
  - else push shreg.
  - Flags assert in the cycle after the stop sample; at most one flag per frame.
- Latency: a good frame's word appears on out_data with out_valid=1 in the cycle after the stop sample, given an empty FIFO.
- Back-to-back frames: with armed=1, a new start may be detected in the cycle right after the stop sample. With BIT_CYCLES=1 frames run contiguously at N+3 cycles each.
- FIFO:
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle are both honoured, including when full, so no overflow in that case.
  - Pointers wrap modulo FIFO_DEPTH; the count is ($clog2(FIFO_DEPTH)+1) bits wide.
  - Read order is strictly FIFO.
  - out_data is don't-care-stable: it holds the last head value when empty.
- Cycle counter width: $clog2(BIT_CYCLES)+1. Bit counter width: $clog2(N+3).

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - function parity_of(data, odd).
  - localparam FRAME_BITS = N+3 helper.
- Sub-module uart_rx_fifo: sync FIFO with push/pop/full/empty/head and parameters WIDTH and DEPTH. The deframer FSM stays in uart_rx_deframer.

Test Plan:
- N=8, BIT_CYCLES=1, PARITY_ODD=0, out_ready=1. Drive rx 1,1 then 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0, stop 1) -> out_valid pulses 1 cycle with out_data=0xA5, one cycle after the stop sample; no flags.
- Same 0xA5 frame with parity bit 1 -> parity_err one pulse; out_valid stays 0. Next correct 0x3C frame, sent back-to-back -> out_data=0x3C.
- 0x5A frame with stop=0, rx then held 0 for 20 cycles, then 1, then a 0x5A frame -> frame_err once; no start during the low period; the following 0x5A is received.
- out_ready=0 and 5 good frames 0x01..0x05 -> overflow on the 5th only. Raise out_ready -> reads 0x01,0x02,0x03,0x04 in order; out_valid then 0.
- BIT_CYCLES=4 with a 1-cycle rx low glitch in idle -> false start, no output. Then a 0xC3 frame at 4 cycles/bit -> out_data=0xC3 with sample points at offset 1 of each bit.
- rst asserted for 1 cycle mid-DATA of frame 0xFF, rx still low just after reset -> no output and no flags until rx is seen high. The following 0x81 frame is received correctly.
